// File: rtl/binary_mul_pkg.sv
// Shared widths, operand/product types and adder-tree sizing helpers for the
// Baugh-Wooley 16x16 signed multiplier.
package binary_mul_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 31;
  localparam int PP_ROWS  = 16;
  localparam int ROW_W    = 4;
  localparam int TREE_OPS = PP_ROWS + 1;

  typedef logic [OP_W-1:0]   operand_t;
  typedef logic [PROD_W-1:0] product_t;

  // Baugh-Wooley correction: +2^16 and +2^31; the 2^31 term falls outside the 31-bit product
  localparam product_t BW_CORR = product_t'(1) << OP_W;

  function automatic int csaNext(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int lvlCount(input int l);
    int n;
    n = TREE_OPS;
    for (int k = 0; k < l; k++) n = csaNext(n);
    return n;
  endfunction

  function automatic int treeLevels();
    int n;
    int l;
    n = TREE_OPS;
    l = 0;
    while (n > 2) begin
      n = csaNext(n);
      l++;
    end
    return l;
  endfunction

  localparam int TREE_LVLS = treeLevels();

endpackage

// File: rtl/binary_mul_pp_row.sv
// One Baugh-Wooley partial-product row: A gated by a single bit of B, with the
// sign-position terms inverted, then shifted left by the row index.
module binary_mul_pp_row
  import binary_mul_pkg::*;
(
  input  operand_t         i_a,
  input  logic             i_b,
  input  logic [ROW_W-1:0] i_row,
  output product_t         o_row
);

  logic [OP_W-1:0] w_bits;
  logic            w_last;

  // The last row inverts every term except a15*b15; all other rows invert only a15*bj
  always_comb begin
    w_bits = i_a & {OP_W{i_b}};
    w_last = (i_row == ROW_W'(PP_ROWS - 1));
    if (w_last) begin
      w_bits[OP_W-2:0] = ~w_bits[OP_W-2:0];
    end else begin
      w_bits[OP_W-1] = ~w_bits[OP_W-1];
    end
  end

  assign o_row = product_t'(w_bits) << i_row;

endmodule

// File: rtl/binary_mul_16_1_bi.sv
// Signed 16x16 Baugh-Wooley multiplier: row array, carry-save tree, ripple CPA and
// a registered 31-bit product. Define BINARY_MUL_INREG_EN to add input registers.
module binary_mul_16_1_bi
  import binary_mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic [30:0] P
);

  operand_t w_a;
  operand_t w_b;

`ifdef BINARY_MUL_INREG_EN
  operand_t r_a;
  operand_t r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (en) begin
      r_a <= A;
      r_b <= B;
    end
  end

  assign w_a = r_a;
  assign w_b = r_b;
`else
  assign w_a = A;
  assign w_b = B;
`endif

  product_t w_pp  [PP_ROWS];
  product_t w_lvl [TREE_LVLS+1][TREE_OPS];

  for (genvar j = 0; j < PP_ROWS; j++) begin : g_row
    binary_mul_pp_row u_row (
      .i_a   (w_a),
      .i_b   (w_b[j]),
      .i_row (ROW_W'(j)),
      .o_row (w_pp[j])
    );
    assign w_lvl[0][j] = w_pp[j];
  end
  assign w_lvl[0][PP_ROWS] = BW_CORR;

  // Each level compresses groups of three operands into sum + shifted carry; leftovers pass through
  for (genvar l = 0; l < TREE_LVLS; l++) begin : g_lvl
    localparam int N  = lvlCount(l);
    localparam int G  = N / 3;
    localparam int R  = N % 3;
    localparam int NN = 2 * G + R;

    for (genvar g = 0; g < G; g++) begin : g_csa
      assign w_lvl[l+1][2*g] = w_lvl[l][3*g] ^ w_lvl[l][3*g+1] ^ w_lvl[l][3*g+2];
      assign w_lvl[l+1][2*g+1] = ((w_lvl[l][3*g] & w_lvl[l][3*g+1]) |
                                  (w_lvl[l][3*g] & w_lvl[l][3*g+2]) |
                                  (w_lvl[l][3*g+1] & w_lvl[l][3*g+2])) << 1;
    end

    for (genvar r = 0; r < R; r++) begin : g_pass
      assign w_lvl[l+1][2*G+r] = w_lvl[l][3*G+r];
    end

    for (genvar k = NN; k < TREE_OPS; k++) begin : g_zero
      assign w_lvl[l+1][k] = '0;
    end
  end

  product_t w_x;
  product_t w_y;
  product_t w_c;
  product_t w_prod;

  // Final ripple-carry adder; the carry out of bit 30 is dropped (modulo 2^31)
  always_comb begin
    w_x    = w_lvl[TREE_LVLS][0];
    w_y    = w_lvl[TREE_LVLS][1];
    w_c    = '0;
    w_prod = '0;
    for (int i = 0; i < PROD_W - 1; i++) begin
      w_prod[i]  = w_x[i] ^ w_y[i] ^ w_c[i];
      w_c[i+1]   = (w_x[i] & w_y[i]) | (w_x[i] & w_c[i]) | (w_y[i] & w_c[i]);
    end
    w_prod[PROD_W-1] = w_x[PROD_W-1] ^ w_y[PROD_W-1] ^ w_c[PROD_W-1];
  end

  product_t r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (en) begin
      r_p <= w_prod;
    end
  end

  assign P = r_p;

endmodule

// File: tb/tb_binary_mul_16_1_bi.sv
// Self-checking bench for binary_mul_16_1_bi: directed sign/extreme/enable/reset
// cases followed by a randomized sweep against an arithmetic reference model.
module tb_binary_mul_16_1_bi;

`ifdef BINARY_MUL_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] A;
  logic [15:0] B;
  logic [30:0] P;

  int nVec  = 0;
  int nMiss = 0;

  logic [30:0] mP;
  logic [15:0] mA;
  logic [15:0] mB;

  always #5 clk = ~clk;

  binary_mul_16_1_bi u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .A     (A),
    .B     (B),
    .P     (P)
  );

  function automatic logic [30:0] refMul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[30:0];
  endfunction

  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic e);
    A  = a;
    B  = b;
    en = e;
  endtask

  task automatic modelReset();
    mP = '0;
    mA = '0;
    mB = '0;
  endtask

  // One rising edge; the model captures what the inputs were at that edge
  task automatic step();
    logic [15:0] sa;
    logic [15:0] sb;
    logic        se;
    logic        sr;
    sa = A;
    sb = B;
    se = en;
    sr = rst_n;
    @(posedge clk);
    if (sr && se) begin
`ifdef BINARY_MUL_INREG_EN
      mP = refMul(mA, mB);
      mA = sa;
      mB = sb;
`else
      mP = refMul(sa, sb);
`endif
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [30:0] exp);
    nVec++;
    assert (P === exp)
    else begin
      nMiss++;
      $error("[TB] FAIL %s: P=%0d (0x%h) expected %0d (0x%h)", tag, P, P, exp, exp);
    end
  endtask

  task automatic runDirected(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [30:0] exp);
    applyStimulus(a, b, 1'b1);
    repeat (LAT) step();
    checkOutput(tag, exp);
  endtask

  initial begin
    rst_n = 1'b1;
    applyStimulus(16'd100, 16'd7, 1'b1);
    #1;
    rst_n = 1'b0;
    modelReset();
    #2;
    checkOutput("reset_async", 31'd0);
    step();
    checkOutput("reset_held", 31'd0);

    rst_n = 1'b1;
    repeat (LAT) step();
    checkOutput("reset_release", 31'd700);
    checkOutput("reset_release_model", mP);

    runDirected("pos_pos", 16'd3, 16'd5, 31'd15);
    runDirected("neg_pos", 16'(-3), 16'd5, 31'(-15));
    runDirected("neg_neg", 16'(-3), 16'(-5), 31'd15);
    runDirected("zero_min", 16'd0, 16'h8000, 31'd0);
    runDirected("max_max", 16'd32767, 16'd32767, 31'd1073676289);
    runDirected("min_max", 16'h8000, 16'd32767, 31'(-1073709056));
    runDirected("min_min_wrap", 16'h8000, 16'h8000, 31'h4000_0000);

    runDirected("hold_setup", 16'd12, 16'd12, 31'd144);
    applyStimulus(16'd9, 16'd9, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("hold_en0", 31'd144);
    end
    applyStimulus(16'd9, 16'd9, 1'b1);
    repeat (LAT) step();
    checkOutput("hold_release", 31'd81);

    runDirected("async_setup", 16'd12, 16'd12, 31'd144);
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_mid", 31'd0);
    #2;
    rst_n = 1'b1;
    step();
    checkOutput("async_after_model", mP);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      int          pick;
      pick = int'($urandom_range(0, 15));
      ra   = (pick == 0) ? 16'h8000 : (pick == 1) ? 16'h7FFF : 16'($urandom);
      pick = int'($urandom_range(0, 15));
      rb   = (pick == 0) ? 16'h8000 : (pick == 1) ? 16'hFFFF : 16'($urandom);
      applyStimulus(ra, rb, ($urandom_range(0, 3) != 0));
      step();
      checkOutput("sweep", mP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
